// File: rtl/mem_op_sequencer.sv
// mem_op_sequencer: element-wise vector engine for a 32-word memory with two
// read ports and one write port. Each element needs three cycles: RD
// (issue both reads), CAP (compute and register the result), and WR (write
// strobe, committed by the memory on the falling edge).
// Optional feature: define MEMSEQ_SAT_EN to make add/sub saturate as signed
// 32-bit values instead of wrapping.
module mem_op_sequencer #(
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [ADDR_BITS-1:0] base_a,
  input  logic [ADDR_BITS-1:0] base_b,
  input  logic [ADDR_BITS-1:0] base_wr,
  input  logic [5:0]           len,
  input  logic [31:0]          read_dataA,
  input  logic [31:0]          read_dataB,
  output logic [31:0]          addrA,
  output logic [31:0]          addrB,
  output logic [31:0]          addrWR,
  output logic [31:0]          write_data,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 busy,
  output logic                 done
);

  localparam int         PAD     = 32 - ADDR_BITS;
  localparam logic [5:0] MAX_LEN = 6'(2 ** ADDR_BITS);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [1:0]           op_q;
  logic [ADDR_BITS-1:0] base_a_q;
  logic [ADDR_BITS-1:0] base_b_q;
  logic [ADDR_BITS-1:0] base_wr_q;
  logic [5:0]           len_q;
  logic [5:0]           idx;

  logic [5:0]           len_clamped;
  logic [5:0]           idx_next;
  logic [ADDR_BITS-1:0] idx_lo;
  logic [ADDR_BITS-1:0] rd_addr_a;
  logic [ADDR_BITS-1:0] rd_addr_b;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [31:0]          sum;
  logic [31:0]          diff;
  logic [31:0]          add_res;
  logic [31:0]          sub_res;
  logic [31:0]          alu_result;

  // Element addresses wrap naturally in ADDR_BITS of width, per stream.
  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign idx_next    = idx + 6'd1;
  assign idx_lo      = idx[ADDR_BITS-1:0];
  assign rd_addr_a   = base_a_q + idx_lo;
  assign rd_addr_b   = base_b_q + idx_lo;
  assign wr_addr     = base_wr_q + idx_lo;
  assign addrA       = {{PAD{1'b0}}, rd_addr_a};
  assign addrB       = {{PAD{1'b0}}, rd_addr_b};

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start only matters in IDLE, so requests made while busy are dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (len_clamped == 6'd0) ? DONE : RD;
        end
      end
      RD:      next_state = CAP;
      CAP:     next_state = WR;
      WR:      next_state = (idx_next < len_q) ? RD : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and status are pure state decodes, so no input reaches an output combinationally.
  always_comb begin
    memread  = (state == RD);
    memwrite = (state == WR);
    done     = (state == DONE);
    busy     = (state != IDLE);
  end

  // Result of the latched operation on the data returned by the RD cycle.
  always_comb begin
    sum     = read_dataA + read_dataB;
    diff    = read_dataA - read_dataB;
    add_res = sum;
    sub_res = diff;
`ifdef MEMSEQ_SAT_EN
    // Signed overflow: same-sign add or opposite-sign sub whose result flips sign.
    if ((read_dataA[31] == read_dataB[31]) && (sum[31] != read_dataA[31])) begin
      add_res = read_dataA[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    if ((read_dataA[31] != read_dataB[31]) && (diff[31] != read_dataA[31])) begin
      sub_res = read_dataA[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`else
`endif
    case (op_q)
      2'b00:   alu_result = add_res;
      2'b01:   alu_result = sub_res;
      2'b10:   alu_result = read_dataA & read_dataB;
      default: alu_result = read_dataA ^ read_dataB;
    endcase
  end

  // Datapath registers: latch the request, capture the result, advance the element index.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 2'b00;
      base_a_q   <= '0;
      base_b_q   <= '0;
      base_wr_q  <= '0;
      len_q      <= 6'd0;
      idx        <= 6'd0;
      write_data <= 32'd0;
      addrWR     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            base_a_q  <= base_a;
            base_b_q  <= base_b;
            base_wr_q <= base_wr;
            len_q     <= len_clamped;
            idx       <= 6'd0;
          end
        end
        CAP: begin
          write_data <= alu_result;
          addrWR     <= {{PAD{1'b0}}, wr_addr};
        end
        WR: begin
          idx <= idx_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// tb_mem_op_sequencer: drives mem_op_sequencer against a behavioural memory and
// compares against an element-by-element reference computed in program order.
module tb_mem_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  base_a;
  logic [4:0]  base_b;
  logic [4:0]  base_wr;
  logic [5:0]  len;
  logic [31:0] read_dataA;
  logic [31:0] read_dataB;
  logic [31:0] addrA;
  logic [31:0] addrB;
  logic [31:0] addrWR;
  logic [31:0] write_data;
  logic        memread;
  logic        memwrite;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem[32];
  logic [31:0] exp_mem[32];
  logic [31:0] addra_log[$];

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -MAXS - 64'sd1;

  mem_op_sequencer #(.ADDR_BITS(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .base_a(base_a),
    .base_b(base_b),
    .base_wr(base_wr),
    .len(len),
    .read_dataA(read_dataA),
    .read_dataB(read_dataB),
    .addrA(addrA),
    .addrB(addrB),
    .addrWR(addrWR),
    .write_data(write_data),
    .memread(memread),
    .memwrite(memwrite),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Memory: synchronous reads one cycle after memread, writes on the falling edge.
  always @(posedge clk) begin
    if (memread) begin
      read_dataA <= mem[addrA[4:0]];
      read_dataB <= mem[addrB[4:0]];
    end
  end

  always @(negedge clk) begin
    if (memwrite) mem[addrWR[4:0]] = write_data;
  end

  // Reference operation on signed 64-bit values, clamped when saturation is built in.
  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
`ifdef MEMSEQ_SAT_EN
    if (r > MAXS) r = MAXS;
    if (r < MINS) r = MINS;
`endif
    return r[31:0];
  endfunction

  // Apply a whole vector operation to exp_mem in program order.
  task automatic model_run(input logic [1:0] o, input int ba, input int bb, input int bw,
                           input int ln);
    int n;
    n = (ln > 32) ? 32 : ln;
    for (int k = 0; k < n; k++)
      exp_mem[(bw + k) % 32] = ref_op(o, exp_mem[(ba + k) % 32], exp_mem[(bb + k) % 32]);
  endtask

  task automatic snapshot();
    for (int i = 0; i < 32; i++) exp_mem[i] = mem[i];
  endtask

  // Issue one request and observe it cycle by cycle until done or a time limit.
  task automatic run_op(input logic [1:0] o, input int ba, input int bb, input int bw,
                        input int ln, input bit noise, output int done_cyc,
                        output int busy_cyc, output int nrd, output int nwr,
                        output int nboth);
    done_cyc = -1;
    busy_cyc = 0;
    nrd = 0;
    nwr = 0;
    nboth = 0;
    addra_log.delete();
    @(posedge clk);
    #1;
    start = 1'b1;
    op = o;
    base_a = 5'(ba);
    base_b = 5'(bb);
    base_wr = 5'(bw);
    len = 6'(ln);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 120 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (memread) begin
        nrd++;
        addra_log.push_back(addrA);
      end
      if (memwrite) nwr++;
      if (memread && memwrite) nboth++;
      if (done) done_cyc = c;
      if (noise && done_cyc < 0) begin
        start = 1'($urandom);
        op = 2'($urandom);
        base_a = 5'($urandom);
        base_b = 5'($urandom);
        base_wr = 5'($urandom);
        len = 6'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout: done never seen, got none, need within 120 cycles");
    end
  endtask

  // Reset forces every output low.
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, memread, memwrite} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_strobes: got %b need 0000", {busy, done, memread, memwrite});
    end
    vectors++;
    if ({addrA, addrB, addrWR, write_data} !== 128'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h %h %h %h need all 0", addrA, addrB, addrWR,
               write_data);
    end
    #1 reset = 1'b0;
  endtask

  // Basic add over four elements with identity-preloaded memory.
  task automatic test_add_basic();
    int dc, bc, nr, nw, nb;
    logic [31:0] want[4];
    want = '{32'd4, 32'd6, 32'd8, 32'd10};
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    snapshot();
    model_run(2'd0, 0, 4, 16, 4);
    run_op(2'd0, 0, 4, 16, 4, 1'b0, dc, bc, nr, nw, nb);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (mem[16 + k] !== want[k] || mem[16 + k] !== exp_mem[16 + k]) begin
        miscompares++;
        $display("[TB] FAIL add_mem%0d: got %0d need %0d", 16 + k, mem[16 + k], want[k]);
      end
    end
    vectors++;
    if (dc !== 13) begin
      miscompares++;
      $display("[TB] FAIL add_done_cycle: got %0d need 13", dc);
    end
    vectors++;
    if (bc !== 13) begin
      miscompares++;
      $display("[TB] FAIL add_busy_cycles: got %0d need 13", bc);
    end
    vectors++;
    if (nr !== 4 || nw !== 4 || nb !== 0) begin
      miscompares++;
      $display("[TB] FAIL add_strobes: got rd=%0d wr=%0d both=%0d need 4 4 0", nr, nw, nb);
    end
  endtask

  // Single-element subtract.
  task automatic test_sub_single();
    int dc, bc, nr, nw, nb;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    run_op(2'd1, 10, 3, 20, 1, 1'b0, dc, bc, nr, nw, nb);
    vectors++;
    if (mem[20] !== 32'd7) begin
      miscompares++;
      $display("[TB] FAIL sub_mem20: got %0d need 7", mem[20]);
    end
    vectors++;
    if (nr !== 1 || nw !== 1 || dc !== 4) begin
      miscompares++;
      $display("[TB] FAIL sub_strobes: got rd=%0d wr=%0d done=%0d need 1 1 4", nr, nw, dc);
    end
  endtask

  // Address wrap with destination feeding the next element's sources.
  task automatic test_wrap();
    int dc, bc, nr, nw, nb;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    run_op(2'd0, 30, 30, 31, 3, 1'b0, dc, bc, nr, nw, nb);
    vectors++;
    if (mem[31] !== 32'd60 || mem[0] !== 32'd120 || mem[1] !== 32'd240) begin
      miscompares++;
      $display("[TB] FAIL wrap_mem: got %0d %0d %0d need 60 120 240", mem[31], mem[0], mem[1]);
    end
    vectors++;
    if (addra_log.size() != 3 || addra_log[0] !== 32'd30 || addra_log[1] !== 32'd31 ||
        addra_log[2] !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL wrap_addrA: got %p need 30 31 0", addra_log);
    end
  endtask

  // Zero-length no-op, then start pulses during a running op.
  task automatic test_len_zero();
    int dc, bc, nr, nw, nb;
    int idle_busy;
    run_op(2'd0, 1, 2, 3, 0, 1'b0, dc, bc, nr, nw, nb);
    vectors++;
    if (dc !== 1 || nr !== 0 || nw !== 0) begin
      miscompares++;
      $display("[TB] FAIL len0: got done=%0d rd=%0d wr=%0d need 1 0 0", dc, nr, nw);
    end
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    snapshot();
    model_run(2'd3, 5, 9, 12, 2);
    run_op(2'd3, 5, 9, 12, 2, 1'b1, dc, bc, nr, nw, nb);
    idle_busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) idle_busy++;
    end
    vectors++;
    if (mem[12] !== exp_mem[12] || mem[13] !== exp_mem[13] || dc !== 7) begin
      miscompares++;
      $display("[TB] FAIL ignore_start: got %h %h done=%0d need %h %h 7", mem[12], mem[13], dc,
               exp_mem[12], exp_mem[13]);
    end
    vectors++;
    if (idle_busy !== 0) begin
      miscompares++;
      $display("[TB] FAIL no_queue: got %0d busy cycles after done need 0", idle_busy);
    end
  endtask

  // Reset arriving in CAP of element 1 aborts the op after element 0's write.
  task automatic test_reset_midop();
    int writes_after;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    snapshot();
    model_run(2'd0, 2, 8, 20, 1);
    @(posedge clk);
    #1;
    start = 1'b1;
    op = 2'd0;
    base_a = 5'd2;
    base_b = 5'd8;
    base_wr = 5'd20;
    len = 6'd4;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    vectors++;
    if (!(busy && !memread && !memwrite)) begin
      miscompares++;
      $display("[TB] FAIL midop_cap: got busy=%b rd=%b wr=%b need 1 0 0", busy, memread,
               memwrite);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, memread, memwrite} !== 4'b0000 ||
        {addrA, addrB, addrWR, write_data} !== 128'd0) begin
      miscompares++;
      $display("[TB] FAIL midop_reset_outputs: got %b %h %h %h %h need all 0",
               {busy, done, memread, memwrite}, addrA, addrB, addrWR, write_data);
    end
    reset = 1'b0;
    writes_after = 0;
    repeat (8) begin
      @(negedge clk);
      if (memwrite || busy) writes_after++;
    end
    vectors++;
    if (writes_after !== 0) begin
      miscompares++;
      $display("[TB] FAIL midop_quiet: got %0d active cycles need 0", writes_after);
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (mem[i] !== exp_mem[i]) begin
        miscompares++;
        $display("[TB] FAIL midop_mem%0d: got %h need %h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  // Signed overflow behaviour for add and sub.
  task automatic test_saturation();
    int dc, bc, nr, nw, nb;
    logic [31:0] want_add, want_sub;
`ifdef MEMSEQ_SAT_EN
    want_add = 32'h7FFF_FFFF;
    want_sub = 32'h8000_0000;
`else
    want_add = 32'hFFFF_FFFE;
    want_sub = 32'h7FFF_FFFF;
`endif
    mem[1] = 32'h7FFF_FFFF;
    run_op(2'd0, 1, 1, 2, 1, 1'b0, dc, bc, nr, nw, nb);
    vectors++;
    if (mem[2] !== want_add) begin
      miscompares++;
      $display("[TB] FAIL sat_add: got %h need %h", mem[2], want_add);
    end
    mem[3] = 32'h8000_0000;
    mem[4] = 32'd1;
    run_op(2'd1, 3, 4, 5, 1, 1'b0, dc, bc, nr, nw, nb);
    vectors++;
    if (mem[5] !== want_sub) begin
      miscompares++;
      $display("[TB] FAIL sat_sub: got %h need %h", mem[5], want_sub);
    end
  endtask

  // Random back-to-back operations, including clamped lengths and busy-time noise.
  task automatic test_random();
    int dc, bc, nr, nw, nb, n, ln, ba, bb, bw;
    logic [1:0] o;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      o = 2'($urandom);
      ba = $urandom_range(0, 31);
      bb = $urandom_range(0, 31);
      bw = $urandom_range(0, 31);
      ln = (t == 0) ? 63 : $urandom_range(0, 40);
      n = (ln > 32) ? 32 : ln;
      snapshot();
      model_run(o, ba, bb, bw, ln);
      run_op(o, ba, bb, bw, ln, 1'b1, dc, bc, nr, nw, nb);
      vectors++;
      if (dc !== 3 * n + 1 || bc !== 3 * n + 1) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_timing: got done=%0d busy=%0d need %0d", t, dc, bc,
                 3 * n + 1);
      end
      vectors++;
      if (nr !== n || nw !== n || nb !== 0) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_strobes: got rd=%0d wr=%0d both=%0d need %0d %0d 0", t, nr,
                 nw, nb, n, n);
      end
      for (int i = 0; i < 32; i++) begin
        vectors++;
        if (mem[i] !== exp_mem[i]) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_mem%0d: got %h need %h", t, i, mem[i], exp_mem[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op = 2'd0;
    base_a = 5'd0;
    base_b = 5'd0;
    base_wr = 5'd0;
    len = 6'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    test_reset();
    test_add_basic();
    test_sub_single();
    test_wrap();
    test_len_zero();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
